// File: rtl/audio_framer.sv
// Audio framer: keeps the newest FRAME_SIZE samples in a circular buffer and
// streams one overlapping analysis frame (oldest sample first) every HOP samples.
// Ports:
//   clk_in, rst_in              system clock, synchronous active-high reset
//   sample_in, sample_valid_in  incoming mono sample stream (1-cycle pulses)
//   frame_data_out/valid/ready  outgoing frame stream (ready/valid handshake)
//   frame_last_out              final word of a frame
//   frame_index_out             word position within the frame, 0 = oldest
//   overrun_out                 sticky error: overwritten pending slot or skipped frame

package audio_framer_pkg;
  localparam int unsigned SYNTH_WIDTH = 16;
endpackage

module audio_framer
  import audio_framer_pkg::*;
#(
  parameter int unsigned FRAME_SIZE = 512,
  parameter int unsigned HOP        = 256
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic signed [SYNTH_WIDTH-1:0]   sample_in,
  input  logic                            sample_valid_in,
  output logic signed [SYNTH_WIDTH-1:0]   frame_data_out,
  output logic                            frame_valid_out,
  input  logic                            frame_ready_in,
  output logic                            frame_last_out,
  output logic [$clog2(FRAME_SIZE)-1:0]   frame_index_out,
  output logic                            overrun_out
);

  localparam int unsigned AW = $clog2(FRAME_SIZE);
  localparam int unsigned KW = AW + 1;
  localparam int unsigned HW = $clog2(HOP + 1);

  typedef enum logic [1:0] {S_FILL, S_IDLE, S_EMIT} state_t;

  state_t                        r_state, w_state_nx;
  logic [AW-1:0]                 r_wr_ptr;
  logic [AW-1:0]                 r_start;
  logic [KW-1:0]                 r_rd_k;
  logic [HW-1:0]                 r_hop_cnt, w_hop_nx;
  logic                          r_valid;
  logic                          r_last;
  logic [AW-1:0]                 r_idx;
  logic signed [SYNTH_WIDTH-1:0] r_data;
  logic                          r_overrun;
  logic signed [SYNTH_WIDTH-1:0] r_mem [FRAME_SIZE];

  logic          w_fire, w_final, w_hop_hit, w_fill_done;
  logic          w_trigger, w_skip, w_issue, w_hazard;
  logic [AW-1:0] w_rd_addr, w_wr_ofs;
  logic [KW-1:0] w_done;

  assign w_fire    = r_valid & frame_ready_in;
  assign w_final   = w_fire & r_last;
  assign w_hop_hit = sample_valid_in && (r_hop_cnt == HW'(HOP - 1));
  // In FILL the write pointer equals the number of samples written since reset.
  assign w_fill_done = sample_valid_in && (r_wr_ptr == AW'(FRAME_SIZE - 1));

  // Read the next word whenever the output holding register is free or draining.
  assign w_issue   = (r_state == S_EMIT) && (r_rd_k < KW'(FRAME_SIZE)) &&
                     (!r_valid || frame_ready_in);
  assign w_rd_addr = r_start + r_rd_k[AW-1:0];

  // Words already handed downstream, counting one transferring this cycle.
  assign w_done   = (r_valid ? {1'b0, r_idx} : r_rd_k) + KW'(w_fire);
  assign w_wr_ofs = r_wr_ptr - r_start;
  assign w_hazard = (r_state == S_EMIT) && sample_valid_in &&
                    ({1'b0, w_wr_ofs} >= w_done);

  // Next-state and hop/trigger decisions.
  always_comb begin
    w_state_nx = r_state;
    w_hop_nx   = r_hop_cnt;
    w_trigger  = 1'b0;
    w_skip     = 1'b0;
    unique case (r_state)
      S_FILL: begin
        if (w_fill_done) begin
          w_trigger  = 1'b1;
          w_hop_nx   = '0;
          w_state_nx = S_EMIT;
        end
      end
      S_IDLE: begin
        if (sample_valid_in) begin
          if (w_hop_hit) begin
            w_trigger  = 1'b1;
            w_hop_nx   = '0;
            w_state_nx = S_EMIT;
          end else begin
            w_hop_nx = r_hop_cnt + HW'(1);
          end
        end
      end
      S_EMIT: begin
        if (w_final) w_state_nx = S_IDLE;
        if (sample_valid_in) begin
          if (w_hop_hit) begin
            w_hop_nx = '0;
            // A hop landing on the final transfer starts the next frame back to back.
            if (w_final) begin
              w_trigger  = 1'b1;
              w_state_nx = S_EMIT;
            end else begin
              w_skip = 1'b1;
            end
          end else begin
            w_hop_nx = r_hop_cnt + HW'(1);
          end
        end
      end
      default: w_state_nx = S_FILL;
    endcase
  end

  // State, pointers and output holding register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= S_FILL;
      r_wr_ptr  <= '0;
      r_start   <= '0;
      r_rd_k    <= '0;
      r_hop_cnt <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_hop_cnt <= w_hop_nx;
      if (sample_valid_in) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_trigger) begin
        r_start <= r_wr_ptr + AW'(1);
        r_rd_k  <= '0;
      end else if (w_issue) begin
        r_rd_k <= r_rd_k + KW'(1);
      end
      if (w_issue) begin
        r_valid <= 1'b1;
        r_idx   <= r_rd_k[AW-1:0];
        r_last  <= (r_rd_k == KW'(FRAME_SIZE - 1));
      end else if (w_fire) begin
        r_valid <= 1'b0;
        r_idx   <= '0;
        r_last  <= 1'b0;
      end
      if (w_skip || w_hazard) r_overrun <= 1'b1;
    end
  end

  // Sample buffer; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (sample_valid_in && !rst_in) r_mem[r_wr_ptr] <= sample_in;
  end

  // Synchronous read port doubles as the output data holding register.
  always_ff @(posedge clk_in) begin
    if (rst_in)       r_data <= '0;
    else if (w_issue) r_data <= r_mem[w_rd_addr];
  end

  assign frame_data_out  = r_data;
  assign frame_valid_out = r_valid;
  assign frame_last_out  = r_last;
  assign frame_index_out = r_idx;
  assign overrun_out     = r_overrun;

endmodule

// File: tb/tb_audio_framer.sv
// Scoreboard bench for audio_framer: a frame-level reference model predicts
// frames, output timing and the overrun flag; a monitor checks every transfer.
module tb_audio_framer;
  import audio_framer_pkg::*;

  localparam int SW = SYNTH_WIDTH;
  localparam int FS = 8;
  localparam int HP = 4;

  logic          clk = 1'b0;
  logic          rst, sv, rdy;
  logic [SW-1:0] sd;
  logic [SW-1:0] fdata;
  logic          fvalid, flast, fover;
  logic [2:0]    fidx;

  logic          rst2, sv2, rdy2;
  logic [SW-1:0] d2, dat2;
  logic          v2, l2, o2;
  logic [2:0]    i2;

  always #5 clk = ~clk;

  audio_framer #(.FRAME_SIZE(FS), .HOP(HP)) u_dut (
    .clk_in(clk), .rst_in(rst), .sample_in(sd), .sample_valid_in(sv),
    .frame_data_out(fdata), .frame_valid_out(fvalid), .frame_ready_in(rdy),
    .frame_last_out(flast), .frame_index_out(fidx), .overrun_out(fover));

  audio_framer #(.FRAME_SIZE(FS), .HOP(1)) u_dut_b (
    .clk_in(clk), .rst_in(rst2), .sample_in(d2), .sample_valid_in(sv2),
    .frame_data_out(dat2), .frame_valid_out(v2), .frame_ready_in(rdy2),
    .frame_last_out(l2), .frame_index_out(i2), .overrun_out(o2));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    logic [SW-1:0] data;
    int            idx;
    bit            last;
    int            fid;
  } exp_t;

  exp_t          exp_q[$];
  logic [SW-1:0] win[$];
  bit            run_chk = 1'b0;
  int            m_filled, m_hop, m_rem, m_delay, m_wr_since, m_fid, taint_fid;
  bit            m_busy, m_over, m_just_reset;

  // Reference model: frame-level rules evaluated once per cycle.
  always @(negedge clk) begin : p_model
    bit ev, fire, trig;
    int pos, done;
    ev = m_busy && (m_delay == 0);
    if (run_chk) begin
      chk("valid", 64'(fvalid), 64'(ev));
      chk("overrun", 64'(fover), 64'(m_over));
      if (!m_busy) chk("idx_idle", 64'(fidx), 64'd0);
      if (m_just_reset) begin
        chk("rst_data", 64'(fdata), 64'd0);
        chk("rst_last", 64'(flast), 64'd0);
        chk("rst_idx", 64'(fidx), 64'd0);
      end
    end
    m_just_reset = 1'b0;
    if (rst) begin
      m_filled = 0; m_hop = 0; m_busy = 1'b0; m_delay = 0; m_rem = 0;
      m_over = 1'b0; m_wr_since = 0; m_just_reset = 1'b1;
      exp_q.delete();
      win.delete();
    end else if (run_chk) begin
      trig = 1'b0;
      if (m_busy && m_delay > 0) m_delay--;
      fire = ev && rdy;
      if (fire) begin
        m_rem--;
        if (m_rem == 0) m_busy = 1'b0;
      end
      if (sv) begin
        win.push_back(sd);
        if (win.size() > FS) void'(win.pop_front());
        if (m_busy) begin
          pos  = m_wr_since % FS;
          done = FS - m_rem;
          if (pos >= done) begin
            m_over    = 1'b1;
            taint_fid = m_fid;
          end
          m_wr_since++;
        end
        if (m_filled < FS) begin
          m_filled++;
          if (m_filled == FS) trig = 1'b1;
        end else begin
          m_hop++;
          if (m_hop == HP) begin
            m_hop = 0;
            if (m_busy) m_over = 1'b1;
            else        trig = 1'b1;
          end
        end
      end
      if (trig) begin
        m_fid++;
        for (int k = 0; k < FS; k++)
          exp_q.push_back('{data: win[k], idx: k, last: (k == FS - 1), fid: m_fid});
        m_busy = 1'b1; m_delay = 1; m_rem = FS; m_wr_since = 0;
      end
    end
  end

  logic [SW-1:0] p_data;
  logic [2:0]    p_idx;
  logic          p_last;
  bit            p_stall = 1'b0;

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  always @(negedge clk) begin : p_mon
    exp_t e;
    if (run_chk) begin
      if (p_stall) begin
        chk("hold_valid", 64'(fvalid), 64'd1);
        chk("hold_data", 64'(fdata), 64'(p_data));
        chk("hold_idx", 64'(fidx), 64'(p_idx));
        chk("hold_last", 64'(flast), 64'(p_last));
      end
      if (!fvalid) chk("last_wo_valid", 64'(flast), 64'd0);
      if (fvalid && rdy) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_word: got idx %0d data %0h expected no word at %0t", fidx, fdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("word_idx", 64'(fidx), 64'(e.idx));
          chk("word_last", 64'(flast), 64'(e.last));
          if (e.fid != taint_fid) chk("word_data", 64'(fdata), 64'(e.data));
        end
      end
    end
    p_stall = run_chk && !rst && fvalid && !rdy;
    p_data  = fdata;
    p_idx   = fidx;
    p_last  = flast;
  end

  // Second instance (HOP=1): frame f starts at sample value 3*f.
  bit run2 = 1'b0;
  bit inst2_done = 1'b0;
  int k2 = 0;
  int f2 = 0;

  always @(negedge clk) begin : p_mon2
    if (run2 && v2) begin
      chk("b_idx", 64'(i2), 64'(k2));
      chk("b_last", 64'(l2), 64'(k2 == FS - 1));
      chk("b_data", 64'(dat2), 64'(SW'(3 * f2 + k2)));
      if (k2 == FS - 1) begin
        k2 = 0;
        f2++;
      end else begin
        k2++;
      end
    end
  end

  initial begin : p_stim2
    rst2 = 1'b1; sv2 = 1'b0; d2 = '0; rdy2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b0; run2 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sv2 = 1'b1; d2 = SW'(i);
      @(posedge clk); #1 sv2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    repeat (20) @(posedge clk);
    inst2_done = 1'b1;
  end

  task automatic cyc(input bit v, input bit r, input bit rs);
    @(posedge clk); #1;
    rst = rs; sv = v; rdy = r; sd = SW'($urandom);
  endtask

  initial begin : p_stim
    rst = 1'b1; sv = 1'b0; rdy = 1'b0; sd = '0;
    repeat (3) cyc(0, 1, 1);
    cyc(0, 1, 0);
    run_chk = 1'b1;

    // Fill, overlap, and backpressure on the second frame at words 2 and 5.
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 0);
      for (int c = 1; c < 16; c++)
        cyc(0, !(i == 11 && ((c >= 4 && c <= 6) || (c >= 10 && c <= 12))), 0);
    end
    chk("overrun_clean", 64'(fover), 64'd0);
    chk("drain_a", 64'(exp_q.size()), 64'd0);

    // Reset while word 3 of a frame is presented.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0);
      repeat (15) cyc(0, 1, 0);
    end
    cyc(1, 1, 0);
    repeat (4) cyc(0, 1, 0);
    cyc(0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0);
      repeat (15) cyc(0, 1, 0);
    end
    chk("drain_b", 64'(exp_q.size()), 64'd0);

    // Random sample spacing and random backpressure.
    for (int i = 0; i < 60; i++) begin
      int gap;
      gap = $urandom_range(1, 20);
      cyc(1, $urandom_range(0, 3) != 0, 0);
      repeat (gap - 1) cyc(0, $urandom_range(0, 3) != 0, 0);
    end
    repeat (30) cyc(0, 1, 0);
    chk("drain_c", 64'(exp_q.size()), 64'd0);

    // Long stall after word 0 while samples keep arriving.
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      cyc(1, 1, 0);
      repeat (15) cyc(0, 1, 0);
    end
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    for (int c = 3; c < 43; c++) cyc((c % 16) == 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0);
      repeat (15) cyc(0, 1, 0);
    end
    repeat (20) cyc(0, 1, 0);
    chk("overrun_sticky", 64'(fover), 64'd1);
    chk("drain_d", 64'(exp_q.size()), 64'd0);

    chk("b_done", 64'(inst2_done), 64'd1);
    chk("b_overrun", 64'(o2), 64'd1);
    chk("b_frames", 64'(f2), 64'd11);
    chk("b_partial", 64'(k2), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d checks passed", n_pass, n_chk);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/audio_framer.md
Name: audio_framer

Overview:
Consumes the 48 kHz mono sample stream from the I2S microphone front end (one-cycle valid pulses) and keeps the most recent FRAME_SIZE samples in a circular buffer. Every HOP new samples it emits one overlapping analysis frame, oldest sample first, on a ready/valid stream that feeds the vocoder FFT stage. Runs entirely in the system clock domain.

Parameters:
FRAME_SIZE, 512, samples per emitted frame; power of two, 4..4096.
HOP, 256, new samples between frame starts; 1 <= HOP <= FRAME_SIZE.
(Sample width is SYNTH_WIDTH, taken from the constants package.)

Ports:
clk_in  input  1  system clock.
rst_in  input  1  synchronous, active-high reset.
sample_in  input  SYNTH_WIDTH  signed sample; sampled only when sample_valid_in=1.
sample_valid_in  input  1  single-cycle pulse per new sample.
frame_data_out  output  SYNTH_WIDTH  signed frame sample.
frame_valid_out  output  1  frame_data_out is valid.
frame_ready_in  input  1  downstream accepts the word; a transfer occurs when valid and ready are both 1.
frame_last_out  output  1  high with the final word (index FRAME_SIZE-1) of a frame.
frame_index_out  output  clog2(FRAME_SIZE)  position of the current word in its frame, 0 = oldest.
overrun_out  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset is synchronous, active-high. It clears:
  - all pointers and counters;
  - state to FILL;
  - all outputs to 0, including overrun_out.
  - Buffer contents are not cleared.
  - Reset mid-frame aborts the frame immediately; no frame_last_out is produced.
- Writes:
  - Every sample_valid_in writes sample_in at wr_ptr, then wr_ptr = (wr_ptr+1) mod FRAME_SIZE.
  - Writes happen in every state and are never stalled or dropped.
- States:
  - FILL: counts written samples. When the FRAME_SIZE-th sample is written, trigger a frame and go to EMIT. hop_cnt is set to 0.
  - IDLE: hop_cnt increments on each write. When a write makes hop_cnt reach HOP, trigger a frame, set hop_cnt to 0, and go to EMIT.
  - EMIT: streams FRAME_SIZE words, then returns to IDLE on the transfer with frame_last_out=1. hop_cnt keeps counting writes during EMIT.
- Trigger and frame contents:
  - At the trigger, snapshot start = wr_ptr after the triggering write. This is the oldest sample.
  - Word k reads buffer[(start+k) mod FRAME_SIZE], for k = 0..FRAME_SIZE-1.
- Latency:
  - The buffer is a synchronous-read memory.
  - Word 0 appears with frame_valid_out=1 exactly 2 cycles after the cycle in which the triggering sample_valid_in was high.
  - With frame_ready_in held at 1, frame_valid_out stays high for FRAME_SIZE consecutive cycles, with no bubbles.
- Backpressure:
  - While frame_valid_out=1 and frame_ready_in=0, frame_data_out, frame_index_out and frame_last_out are held stable.
  - frame_valid_out never deasserts before its transfer.
  - Use a skid/holding register, so no word is lost or duplicated.
- Overwrite hazard:
  - If a write during EMIT lands on a slot not yet transferred in the current frame, set overrun_out=1.
  - The frame still completes with whatever the buffer holds.
- Trigger while busy:
  - If hop_cnt reaches HOP while still in EMIT, that frame is skipped, not queued.
  - Set overrun_out=1 and hop_cnt to 0; the current frame continues.
- Simultaneous events: a write in the same cycle as the final transfer is counted normally. If that write completes a hop, the next frame triggers in the same cycle and the FSM goes EMIT→EMIT.
- frame_index_out is 0 outside EMIT.
- frame_last_out is only ever high together with frame_valid_out.

Test Plan:
- Fill. FRAME_SIZE=8, HOP=4, ready=1, samples 0,1,2,… with valid every 16 cycles → after sample 7, frame_valid_out rises exactly 2 cycles later. Frame carries 0..7 in 8 consecutive cycles, index 0..7, last on the word with value 7.
- Overlap. Continue the same stream → frame 2 follows sample 11 and carries 4..11. Frame 3 follows sample 15 and carries 8..15. overrun_out stays 0.
- Backpressure. During frame 2, drop ready on indices 2 and 5 for 3 cycles each → data/index/last stay stable while stalled. All 8 words are delivered in order exactly once.
- Overwrite. HOP=4, ready held low for 40 cycles after word 0 of a frame, samples every 16 cycles → overrun_out becomes 1 and stays 1. The frame still ends with exactly one last.
- Busy skip. HOP=1, samples every 4 cycles, ready=1 → overrun_out=1. Frames never interleave. Each frame has 8 words with one last.
- Reset mid-frame. Assert rst_in at index 3 → next cycle all outputs are 0 and the FSM is in FILL. The next frame appears only after 8 new samples and contains those samples.
